// File: rtl/snd_irq_pkg.sv
// -----------------------------------------------------------------------------
// snd_irq_pkg
//   Shared types and helpers for the sound-CPU interrupt arbiter.
//   - trig_mode_t : per-source trigger mode (edge / level)
//   - VEC_STRIDE  : vector spacing between adjacent sources (IM2 table entries
//                   are 16-bit pointers, so consecutive sources are 2 apart)
//   - src_w()     : width of a source index for a given source count
// -----------------------------------------------------------------------------
package snd_irq_pkg;

    typedef enum logic {
        TRIG_EDGE  = 1'b0,
        TRIG_LEVEL = 1'b1
    } trig_mode_t;

    localparam int VEC_STRIDE = 2;

    // Index width for n sources; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snd_irq_pick.sv
// -----------------------------------------------------------------------------
// snd_irq_pick
//   Combinational selector: picks one request out of req and returns it as a
//   one-hot bit and as an index.
//   ROTATE=0 : lowest index wins, `last` is ignored.
//   ROTATE=1 : search starts at last+1 and wraps modulo NUM_SRC (round robin).
//
// Ports
//   req    in  NUM_SRC  candidate bitmap (already qualified by mask)
//   last   in  IDW      previously granted index (round-robin start point)
//   onehot out NUM_SRC  selected source, one-hot; zero when none
//   idx    out IDW      selected source index; zero when none
//   any    out 1        a source was selected
// -----------------------------------------------------------------------------
module snd_irq_pick
    import snd_irq_pkg::*;
#(
    parameter int   NUM_SRC = 4,
    parameter bit   ROTATE  = 1'b0,
    localparam int  IDW     = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    always_comb begin
        int             base;
        int             j;
        logic [IDW-1:0] jj;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        base   = 0;
        j      = 0;
        jj     = '0;
        // Start one past the last winner; wrap explicitly so non-power-of-two
        // source counts stay in range.
        if (ROTATE)
            base = (int'(last) >= NUM_SRC - 1) ? 0 : int'(last) + 1;
        for (int i = 0; i < NUM_SRC; i++) begin
            j  = (base + i >= NUM_SRC) ? base + i - NUM_SRC : base + i;
            jj = IDW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/snd_irq_arbiter.sv
// -----------------------------------------------------------------------------
// snd_irq_arbiter
//   Sound-CPU interrupt controller. Latches NUM_SRC trigger sources as pending,
//   arbitrates among the unmasked ones and drives the Z80 INT_n line with an
//   IM2 vector (VEC_BASE + 2*k). After an acknowledge INT_n is held high for at
//   least GAP_CEN cen ticks to stop interrupt storms.
//
//   Build option: define SND_IRQ_RR_EN for round-robin arbitration (search
//   starts after the last granted source). Undefined: fixed priority, lowest
//   index wins.
//
// Ports
//   clk_49m   in  1               system clock
//   sirq_clr  in  1               async active-high reset / acknowledge
//   cen       in  1               sound clock enable; all state moves only here
//   flush     in  1               clears pending and overrun (on cen)
//   trig      in  NUM_SRC         raw trigger inputs
//   trig_mode in  NUM_SRC         0 = rising edge, 1 = level
//   mask      in  NUM_SRC         1 = source may be granted
//   irq_n     out 1               Z80 INT_n, active low
//   vector    out 8               IM2 vector of in-service source, FF when idle
//   src_id    out clog2(NUM_SRC)  in-service source index, 0 when idle
//   pending   out NUM_SRC         pending bitmap
//   overrun   out NUM_SRC         sticky: edge arrived while already pending
// -----------------------------------------------------------------------------
module snd_irq_arbiter
    import snd_irq_pkg::*;
#(
    parameter int         NUM_SRC  = 4,
    parameter logic [7:0] VEC_BASE = 8'hE0,
    parameter int         GAP_CEN  = 2
) (
    input  logic                       clk_49m,
    input  logic                       sirq_clr,
    input  logic                       cen,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         trig,
    input  logic [NUM_SRC-1:0]         trig_mode,
    input  logic [NUM_SRC-1:0]         mask,
    output logic                       irq_n,
    output logic [7:0]                 vector,
    output logic [src_w(NUM_SRC)-1:0]  src_id,
    output logic [NUM_SRC-1:0]         pending,
    output logic [NUM_SRC-1:0]         overrun
);

    localparam int         IDW      = src_w(NUM_SRC);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CEN);

    logic [NUM_SRC-1:0] hist;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] is_edge;
    logic [NUM_SRC-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               grant_en;
    logic [NUM_SRC-1:0] grant_oh;
    logic [3:0]         gap;
    logic [IDW-1:0]     last_grant;

    // ---------------------------------------------------------------- sampling
    always_comb begin
        evt     = '0;
        is_edge = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            is_edge[k] = (trig_mode_t'(trig_mode[k]) == TRIG_EDGE);
            evt[k]     = trig[k] & (is_edge[k] ? ~hist[k] : 1'b1);
        end
    end

    // ---------------------------------------------------------------- arbitration
    // Selection looks at the registered pending bitmap, so an event arriving
    // on this tick can only be granted on a later one.
`ifdef SND_IRQ_RR_EN
    localparam bit ROTATE = 1'b1;

    // Last-granted pointer. No reset: it survives acknowledges and starts
    // from the zeroed configuration state.
    always_ff @(posedge clk_49m) begin
        if (grant_en)
            last_grant <= pick_idx;
    end
`else
    localparam bit ROTATE = 1'b0;

    assign last_grant = '0;
`endif

    snd_irq_pick #(
        .NUM_SRC (NUM_SRC),
        .ROTATE  (ROTATE)
    ) u_pick (
        .req     (pending & mask),
        .last    (last_grant),
        .onehot  (pick_oh),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign grant_en = cen & irq_n & (gap == 4'd0) & ~sirq_clr & pick_any;
    assign grant_oh = grant_en ? pick_oh : '0;

    // ---------------------------------------------------------------- pending
    // Deliberately outside the acknowledge reset: an acknowledge must never
    // drop a queued source. These registers rely on the zeroed power-up
    // state and are otherwise cleared only by flush or by a grant.
    always_ff @(posedge clk_49m) begin
        if (cen) begin
            hist <= trig;
            if (flush) begin
                pending <= '0;
                overrun <= '0;
            end else begin
                // A grant and a new event on the same source in one tick
                // re-arms it without counting as an overrun.
                pending <= (pending & ~grant_oh) | evt;
                overrun <= overrun | (evt & is_edge & pending & ~grant_oh);
            end
        end
    end

    // ---------------------------------------------------------------- INT_n
    // irq_n low is the in-service state; only the acknowledge returns it high.
    always_ff @(posedge clk_49m or posedge sirq_clr) begin
        if (sirq_clr) begin
            irq_n  <= 1'b1;
            src_id <= '0;
            vector <= 8'hFF;
            gap    <= GAP_INIT;
        end else if (cen) begin
            if (gap != 4'd0)
                gap <= gap - 4'd1;
            if (grant_en) begin
                irq_n  <= 1'b0;
                src_id <= pick_idx;
                vector <= VEC_BASE + 8'(VEC_STRIDE * int'(pick_idx));
            end
        end
    end

endmodule

// File: tb/tb_snd_irq_arbiter.sv
module tb_snd_irq_arbiter;

    localparam int         N        = 4;
    localparam logic [7:0] VEC_BASE = 8'hE0;
    localparam int         GAP      = 2;

    logic         clk_49m;
    logic         sirq_clr;
    logic         cen;
    logic         flush;
    logic [N-1:0] trig;
    logic [N-1:0] trig_mode;
    logic [N-1:0] mask;
    logic         irq_n;
    logic [7:0]   vector;
    logic [1:0]   src_id;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    snd_irq_arbiter #(
        .NUM_SRC  (N),
        .VEC_BASE (VEC_BASE),
        .GAP_CEN  (GAP)
    ) dut (
        .clk_49m   (clk_49m),
        .sirq_clr  (sirq_clr),
        .cen       (cen),
        .flush     (flush),
        .trig      (trig),
        .trig_mode (trig_mode),
        .mask      (mask),
        .irq_n     (irq_n),
        .vector    (vector),
        .src_id    (src_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial begin
        clk_49m = 0;
        forever #10 clk_49m = ~clk_49m;
    end

    // cen high for exactly one rising edge out of every 16
    initial begin
        cen = 0;
        forever begin
            repeat (15) @(posedge clk_49m);
            #1 cen = 1;
            @(posedge clk_49m);
            #1 cen = 0;
        end
    end

    // ------------------------------------------------------------ model
    bit [N-1:0] m_pend = '0;
    bit [N-1:0] m_ovr  = '0;
    bit [N-1:0] m_hist = '0;
    bit         m_irq  = 1;
    int         m_src  = 0;
    int         m_gap  = GAP;
`ifdef SND_IRQ_RR_EN
    int         m_ptr  = 0;
`endif
    int         rst_cnt = 0;
    int         rst_ack = 0;

    always @(posedge sirq_clr) rst_cnt++;

    always @(posedge clk_49m) begin
        int         g;
        int         k;
        bit         ev;
        bit [N-1:0] nxt_p;
        bit [N-1:0] nxt_o;
        if (sirq_clr || rst_cnt != rst_ack) begin
            m_irq   = 1;
            m_src   = 0;
            m_gap   = GAP;
            rst_ack = rst_cnt;
        end
        if (cen) begin
            g = -1;
            if (!sirq_clr && m_irq && m_gap == 0) begin
                for (int i = 0; i < N; i++) begin
`ifdef SND_IRQ_RR_EN
                    k = (m_ptr + 1 + i) % N;
`else
                    k = i;
`endif
                    if (g < 0 && m_pend[k] && mask[k]) g = k;
                end
            end
            for (int s = 0; s < N; s++) begin
                ev = trig[s] && (trig_mode[s] || !m_hist[s]);
                if (flush) begin
                    nxt_p[s] = 0;
                    nxt_o[s] = 0;
                end else begin
                    nxt_p[s] = (m_pend[s] && s != g) || ev;
                    nxt_o[s] = m_ovr[s] || (ev && !trig_mode[s] && m_pend[s] && s != g);
                end
            end
            m_pend = nxt_p;
            m_ovr  = nxt_o;
            m_hist = trig;
            if (!sirq_clr && m_gap > 0) m_gap--;
            if (g >= 0) begin
                m_irq = 0;
                m_src = g;
`ifdef SND_IRQ_RR_EN
                m_ptr = g;
`endif
            end
        end
    end

    // ------------------------------------------------------------ checking
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit rst_now;
        bit e_irq;
        rst_now = sirq_clr || (rst_cnt != rst_ack);
        e_irq   = rst_now ? 1'b1 : m_irq;
        chk("cmp irq_n", 32'(irq_n), 32'(e_irq));
        chk("cmp vector", 32'(vector), e_irq ? 32'hFF : 32'(8'(VEC_BASE + 2 * m_src)));
        chk("cmp src_id", 32'(src_id), rst_now ? 0 : 32'(m_src));
        chk("cmp pending", 32'(pending), 32'(m_pend));
        chk("cmp overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // ------------------------------------------------------------ stimulus
    // Returns 2 time units after the next enabled edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            do @(posedge clk_49m); while (!cen);
        end
        #2;
    endtask

    task automatic ack();
        sirq_clr = 1;
        #3;
        sirq_clr = 0;
    endtask

    task automatic run_stim();
        logic [7:0] v2a, v2b;
        logic [3:0] p2a;
`ifdef SND_IRQ_RR_EN
        v2a = 8'hE4; v2b = 8'hE0; p2a = 4'b0001;
`else
        v2a = 8'hE0; v2b = 8'hE4; p2a = 4'b0100;
`endif
        sirq_clr = 1; flush = 1; trig = '0; trig_mode = '0; mask = '1;
        tick(2);
        cmp_en = 1;
        chk("reset irq_n", 32'(irq_n), 1);
        chk("reset vector", 32'(vector), 32'hFF);
        chk("reset src_id", 32'(src_id), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset overrun", 32'(overrun), 0);
        sirq_clr = 0; flush = 0;
        tick(3);

        // 1: single edge source, two-tick latency
        trig = 4'b0010;
        tick();
        trig = 4'b0000;
        chk("s1 pend after T", 32'(pending), 32'b0010);
        chk("s1 irq after T", 32'(irq_n), 1);
        tick();
        chk("s1 irq_n", 32'(irq_n), 0);
        chk("s1 vector", 32'(vector), 32'hE2);
        chk("s1 src_id", 32'(src_id), 1);
        chk("s1 pending", 32'(pending), 0);
        ack();
        chk("s1 ack vector", 32'(vector), 32'hFF);
        tick(3);

        // 2/3: two sources pending together
        trig = 4'b0101;
        tick();
        trig = 4'b0000;
        tick();
        chk("s2 first vector", 32'(vector), 32'(v2a));
        chk("s2 first pending", 32'(pending), 32'(p2a));
        ack();
        tick();
        chk("s2 gap1 irq_n", 32'(irq_n), 1);
        tick();
        chk("s2 gap2 irq_n", 32'(irq_n), 1);
        tick();
        chk("s2 second irq_n", 32'(irq_n), 0);
        chk("s2 second vector", 32'(vector), 32'(v2b));
        chk("s2 pending", 32'(pending), 0);
        ack();
        tick(3);

        // 4: masked source with overrun, unmask, flush
        mask = 4'b0111;
        trig = 4'b1000; tick();
        trig = 4'b0000; tick();
        trig = 4'b1000; tick();
        trig = 4'b0000;
        chk("s4 pending", 32'(pending), 32'b1000);
        chk("s4 overrun", 32'(overrun), 32'b1000);
        chk("s4 irq masked", 32'(irq_n), 1);
        tick();
        chk("s4 irq still masked", 32'(irq_n), 1);
        mask = 4'b1111;
        tick();
        chk("s4 grant vector", 32'(vector), 32'hE6);
        chk("s4 grant src", 32'(src_id), 3);
        chk("s4 ovr kept", 32'(overrun), 32'b1000);
        flush = 1; trig = 4'b0100;
        tick();
        flush = 0;
        chk("s4 flush overrun", 32'(overrun), 0);
        chk("s4 flush beats event", 32'(pending), 0);
        tick();
        chk("s4 held edge no event", 32'(pending), 0);
        chk("s4 hold vector", 32'(vector), 32'hE6);
        trig = 4'b0000;
        ack();
        tick(3);

        // 5: level source held across an acknowledge
        trig_mode = 4'b0001; trig = 4'b0001;
        tick(2);
        chk("s5 vector", 32'(vector), 32'hE0);
        chk("s5 re-pending", 32'(pending), 32'b0001);
        ack();
        tick();
        chk("s5 gap1 irq_n", 32'(irq_n), 1);
        tick();
        chk("s5 gap2 irq_n", 32'(irq_n), 1);
        tick();
        chk("s5 reassert irq_n", 32'(irq_n), 0);
        chk("s5 overrun", 32'(overrun), 0);
        trig = 4'b0000; trig_mode = 4'b0000; flush = 1;
        tick();
        flush = 0;
        chk("s5 flushed", 32'(pending), 0);
        ack();
        tick(3);

        // 6: acknowledge mid-hold with another event queued
        trig = 4'b0010; tick();
        trig = 4'b0000; tick();
        chk("s6 first vector", 32'(vector), 32'hE2);
        trig = 4'b0010; tick();
        trig = 4'b0000;
        chk("s6 queued", 32'(pending), 32'b0010);
        sirq_clr = 1;
        #1;
        chk("s6 async irq_n", 32'(irq_n), 1);
        chk("s6 async vector", 32'(vector), 32'hFF);
        chk("s6 async src_id", 32'(src_id), 0);
        chk("s6 pend kept", 32'(pending), 32'b0010);
        #2;
        sirq_clr = 0;
        tick(2);
        chk("s6 gap irq_n", 32'(irq_n), 1);
        tick();
        chk("s6 regrant vector", 32'(vector), 32'hE2);
        chk("s6 pending", 32'(pending), 0);
        ack();
        tick(2);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk_49m);
                    if (cmp_en) check_outputs();
                end
            end
            run_stim();
            begin
                #2000000;
                n_fail++;
                $display("FAIL watchdog: stimulus not done at t=%0t, required completion", $time);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
